// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32 opcode constants, instruction field positions and operand-use decode.
package rv32_pkg;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam int OPC_LSB = 0;
   localparam int OPC_W   = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;

   // bit 0 = rs1 used, bit 1 = rs2 used; unknown opcodes conservatively use both
   function automatic logic [1:0] use_mask(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL:                return 2'b00;
         OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:  return 2'b01;
         OPC_OP, OPC_STORE, OPC_BRANCH:              return 2'b11;
         default:                                    return 2'b11;
      endcase
   endfunction
endpackage

// File: rtl/decode_fwd_stage_if.sv
// decode_fwd_stage_if: upstream, forwarding and downstream signals of the decode/forward stage.
interface decode_fwd_stage_if #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5
);
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [31:0]             ins_dec_in;
   logic [XLEN-1:0]         rso1;
   logic [XLEN-1:0]         rso2;
   logic [NUM_FWD-1:0]      fwd_valid;
   logic [NUM_FWD-1:0]      fwd_pend;
   logic [NUM_FWD*RA_W-1:0] fwd_rd;
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         alu_in1;
   logic [XLEN-1:0]         alu_in2;
   logic [31:0]             ins_dec_out;
   logic                    hazard;

   modport master (
      output flush, in_valid, ins_dec_in, rso1, rso2, fwd_valid, fwd_pend, fwd_rd, fwd_data, out_ready,
      input  in_ready, out_valid, alu_in1, alu_in2, ins_dec_out, hazard
   );
   modport slave (
      input  flush, in_valid, ins_dec_in, rso1, rso2, fwd_valid, fwd_pend, fwd_rd, fwd_data, out_ready,
      output in_ready, out_valid, alu_in1, alu_in2, ins_dec_out, hazard
   );
endinterface

// File: rtl/fwd_mux.sv
// fwd_mux: priority forwarding select for one operand; lowest index (youngest) source wins.
module fwd_mux #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5
) (
   input  logic [RA_W-1:0]         i_rs,
   input  logic                    i_used,
   input  logic [XLEN-1:0]         i_rso,
   input  logic [NUM_FWD-1:0]      i_fwd_valid,
   input  logic [NUM_FWD-1:0]      i_fwd_pend,
   input  logic [NUM_FWD*RA_W-1:0] i_fwd_rd,
   input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
   output logic [XLEN-1:0]         o_data,
   output logic                    o_pend_hit
);
   always_comb begin
      o_data     = i_rso;
      o_pend_hit = 1'b0;
      if (i_used) begin
         // walk oldest to youngest so the youngest match overwrites
         for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_fwd_valid[i] && i_fwd_rd[i*RA_W +: RA_W] == i_rs) begin
               o_data     = i_fwd_data[i*XLEN +: XLEN];
               o_pend_hit = i_fwd_pend[i];
            end
         end
         if (i_rs == '0) begin
            o_data     = '0;
            o_pend_hit = 1'b0;
         end
      end
   end
endmodule

// File: rtl/decode_fwd_stage.sv
// decode_fwd_stage: resolves rs1/rs2 via forwarding, stalls on load-use, registers
// the instruction and operands behind a valid/ready handshake with flush.
module decode_fwd_stage
   import rv32_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5
) (
   input logic              clk,
   input logic              rst,
   decode_fwd_stage_if.slave bus
);
   logic [1:0]      w_use;
   logic [RA_W-1:0] w_rs1;
   logic [RA_W-1:0] w_rs2;
   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;
   logic            w_pend1;
   logic            w_pend2;
   logic            w_hazard;
   logic            w_ready;
   logic            r_valid;
   logic [XLEN-1:0] r_alu1;
   logic [XLEN-1:0] r_alu2;
   logic [31:0]     r_ins;

   assign w_use = use_mask(bus.ins_dec_in[OPC_LSB +: OPC_W]);
   assign w_rs1 = bus.ins_dec_in[RS1_LSB +: RA_W];
   assign w_rs2 = bus.ins_dec_in[RS2_LSB +: RA_W];

   fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) u_mux1 (
      .i_rs(w_rs1), .i_used(w_use[0]), .i_rso(bus.rso1),
      .i_fwd_valid(bus.fwd_valid), .i_fwd_pend(bus.fwd_pend),
      .i_fwd_rd(bus.fwd_rd), .i_fwd_data(bus.fwd_data),
      .o_data(w_op1), .o_pend_hit(w_pend1)
   );

   fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) u_mux2 (
      .i_rs(w_rs2), .i_used(w_use[1]), .i_rso(bus.rso2),
      .i_fwd_valid(bus.fwd_valid), .i_fwd_pend(bus.fwd_pend),
      .i_fwd_rd(bus.fwd_rd), .i_fwd_data(bus.fwd_data),
      .o_data(w_op2), .o_pend_hit(w_pend2)
   );

   assign w_hazard = bus.in_valid && (w_pend1 || w_pend2);
   assign w_ready  = (!r_valid || bus.out_ready) && !w_hazard && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_alu1  <= '0;
         r_alu2  <= '0;
         r_ins   <= '0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
      end else if (bus.in_valid && w_ready) begin
         r_valid <= 1'b1;
         r_alu1  <= w_op1;
         r_alu2  <= w_op2;
         r_ins   <= bus.ins_dec_in;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.in_ready    = w_ready;
   assign bus.hazard      = w_hazard;
   assign bus.out_valid   = r_valid;
   assign bus.alu_in1     = r_alu1;
   assign bus.alu_in2     = r_alu2;
   assign bus.ins_dec_out = r_ins;
endmodule

// File: tb/tb_decode_fwd_stage.sv
// tb_decode_fwd_stage: directed scenarios plus randomized traffic checked against a
// cycle-level reference model of the decode/forward stage.
module tb_decode_fwd_stage;
   localparam int XLEN    = 32;
   localparam int NUM_FWD = 2;
   localparam int RA_W    = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_fwd_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) bus ();
   decode_fwd_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [RA_W-1:0] frd  [NUM_FWD];
   logic [XLEN-1:0] fdat [NUM_FWD];
   always_comb begin
      bus.fwd_rd   = '0;
      bus.fwd_data = '0;
      for (int i = 0; i < NUM_FWD; i++) begin
         bus.fwd_rd[i*RA_W +: RA_W]   = frd[i];
         bus.fwd_data[i*XLEN +: XLEN] = fdat[i];
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   bit m_known = 0;
   bit m_v;
   logic [XLEN-1:0] m_a1, m_a2;
   logic [31:0] m_ins;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic void uses(input logic [6:0] opc, output bit u1, output bit u2);
      case (opc)
         7'b0110111, 7'b0010111, 7'b1101111:             begin u1 = 0; u2 = 0; end
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin u1 = 1; u2 = 0; end
         default:                                        begin u1 = 1; u2 = 1; end
      endcase
   endfunction

   function automatic logic [XLEN-1:0] resolve(input int rs, input bit used, input logic [XLEN-1:0] rso, output bit pend);
      pend = 0;
      if (!used) return rso;
      if (rs == 0) return '0;
      for (int i = 0; i < NUM_FWD; i++)
         if (bus.fwd_valid[i] && int'(frd[i]) == rs) begin
            pend = bus.fwd_pend[i];
            return fdat[i];
         end
      return rso;
   endfunction

   // one clock: check against the model, advance the model, return at the next negedge
   task automatic step();
      bit u1, u2, p1, p2, eh, er;
      logic [XLEN-1:0] o1, o2;
      #1;
      uses(bus.ins_dec_in[6:0], u1, u2);
      o1 = resolve(int'(bus.ins_dec_in[19:15]), u1, bus.rso1, p1);
      o2 = resolve(int'(bus.ins_dec_in[24:20]), u2, bus.rso2, p2);
      eh = bus.in_valid && (p1 || p2);
      er = (!m_v || bus.out_ready) && !eh && !bus.flush;
      if (m_known) begin
         chk("hazard", 32'(bus.hazard), 32'(eh));
         chk("in_ready", 32'(bus.in_ready), 32'(er));
         chk("out_valid", 32'(bus.out_valid), 32'(m_v));
         chk("alu_in1", bus.alu_in1, m_a1);
         chk("alu_in2", bus.alu_in2, m_a2);
         chk("ins_dec_out", bus.ins_dec_out, m_ins);
      end
      if (rst) begin
         m_known = 1; m_v = 0; m_a1 = '0; m_a2 = '0; m_ins = '0;
      end else if (bus.flush) m_v = 0;
      else if (bus.in_valid && er) begin
         m_v = 1; m_a1 = o1; m_a2 = o2; m_ins = bus.ins_dec_in;
      end else if (bus.out_ready) m_v = 0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_fwd(input int i, input bit v, input bit p, input int rd, input logic [XLEN-1:0] d);
      bus.fwd_valid[i] = v;
      bus.fwd_pend[i]  = p;
      frd[i]           = RA_W'(rd);
      fdat[i]          = d;
   endtask

   localparam logic [31:0] OPS [10] = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63,
                                        32'h03, 32'h23, 32'h13, 32'h33, 32'h73};

   initial begin
      logic [31:0] opc;
      rst = 1;
      bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
      bus.ins_dec_in = '0; bus.rso1 = '0; bus.rso2 = '0;
      bus.fwd_valid = '0; bus.fwd_pend = '0;
      for (int i = 0; i < NUM_FWD; i++) begin frd[i] = '0; fdat[i] = '0; end
      @(negedge clk);
      step();
      rst = 0;
      // ADD x3,x1,x2 with rs1 from fwd0 and rs2 from fwd1
      set_fwd(0, 1, 0, 1, 32'hAAAA0000);
      set_fwd(1, 1, 0, 2, 32'h1234);
      bus.ins_dec_in = {7'b0, 5'd2, 5'd1, 3'b0, 5'd3, 7'b0110011};
      bus.in_valid = 1;
      step();
      chk("add_fwd_rs1", bus.alu_in1, 32'hAAAA0000);
      chk("add_fwd_rs2", bus.alu_in2, 32'h1234);
      // both sources target x5: youngest wins
      set_fwd(0, 1, 0, 5, 32'h11);
      set_fwd(1, 1, 0, 5, 32'h22);
      bus.ins_dec_in = {7'b0, 5'd5, 5'd5, 3'b0, 5'd6, 7'b0110011};
      step();
      chk("youngest_rs1", bus.alu_in1, 32'h11);
      chk("youngest_rs2", bus.alu_in2, 32'h11);
      // x0 never forwards even if a source writes x0
      set_fwd(0, 1, 0, 0, 32'hFFFF);
      set_fwd(1, 0, 0, 0, 32'h0);
      bus.ins_dec_in = {12'd7, 5'd0, 3'b0, 5'd1, 7'b0010011};
      step();
      chk("x0_zero", bus.alu_in1, 32'h0);
      // pending source matching the unused rs2 field does not stall
      set_fwd(0, 1, 1, 7, 32'hDEAD);
      bus.ins_dec_in = {12'd7, 5'd2, 3'b0, 5'd1, 7'b0010011};
      bus.rso1 = 32'h42;
      step();
      chk("unused_no_haz", 32'(bus.hazard), 32'd0);
      chk("unused_xfer", bus.alu_in1, 32'h42);
      // load-use on x4 for two cycles
      set_fwd(0, 1, 1, 4, 32'h0);
      bus.ins_dec_in = {7'b0, 5'd1, 5'd4, 3'b0, 5'd7, 7'b0110011};
      for (int k = 0; k < 2; k++) begin
         step();
         chk("lu_hazard", 32'(bus.hazard), 32'd1);
         chk("lu_in_ready", 32'(bus.in_ready), 32'd0);
         chk("lu_bubble", 32'(bus.out_valid), 32'd0);
      end
      set_fwd(0, 1, 0, 4, 32'h99);
      step();
      chk("lu_resolved", bus.alu_in1, 32'h99);
      chk("lu_valid", 32'(bus.out_valid), 32'd1);
      // backpressure, then flush drops the waiting instruction
      bus.out_ready = 0;
      set_fwd(0, 0, 0, 0, 32'h0);
      bus.ins_dec_in = {12'd1, 5'd3, 3'b0, 5'd3, 7'b0010011};
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_hold", bus.alu_in1, 32'h99);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.flush = 1;
      step();
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      bus.flush = 0; bus.out_ready = 1;
      // reset mid-stream
      bus.rso1 = 32'h55;
      step();
      chk("pre_rst_a1", bus.alu_in1, 32'h55);
      bus.in_valid = 0;
      rst = 1;
      step();
      rst = 0;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_a1", bus.alu_in1, 32'h0);
      chk("rst_ins", bus.ins_dec_out, 32'h0);
      // randomized traffic with small register numbers to provoke matches
      for (int c = 0; c < 2000; c++) begin
         rst = ($urandom_range(63) == 0);
         bus.flush = ($urandom_range(9) == 0);
         bus.in_valid = ($urandom_range(3) != 0);
         bus.out_ready = ($urandom_range(3) != 0);
         opc = ($urandom_range(10) == 10) ? 32'($urandom_range(127)) : OPS[$urandom_range(9)];
         bus.ins_dec_in = {7'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)), 3'($urandom), 5'($urandom), opc[6:0]};
         bus.rso1 = $urandom;
         bus.rso2 = $urandom;
         for (int i = 0; i < NUM_FWD; i++)
            set_fwd(i, $urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(7), $urandom);
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/decode_fwd_stage.md
Name: decode_fwd_stage

Overview:
- Parametrised decode / operand-forwarding pipeline stage for the RV32 core, between fetch/regfile read and the ALU.
- Resolves rs1/rs2 from the register file or from NUM_FWD forwarding sources, ordered youngest first.
- Detects load-use hazards and stalls on them.
- Registers the instruction and both operands behind a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, datapath width.
- NUM_FWD, 2, forwarding sources; index 0 = youngest (EX), highest = oldest (WB).
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill held and incoming instruction (branch redirect)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- ins_dec_in  in  32  instruction word
- rso1  in  XLEN  regfile read data for rs1
- rso2  in  XLEN  regfile read data for rs2
- fwd_valid  in  NUM_FWD  source i will write rd
- fwd_pend  in  NUM_FWD  source i result not yet available (load in flight)
- fwd_rd  in  NUM_FWD*RA_W  destination register of source i, packed
- fwd_data  in  NUM_FWD*XLEN  result of source i, packed
- out_valid  out  1  registered outputs valid
- out_ready  in  1  downstream accepts
- alu_in1  out  XLEN  resolved rs1 operand
- alu_in2  out  XLEN  resolved rs2 operand
- ins_dec_out  out  32  registered instruction
- hazard  out  1  combinational load-use stall indicator

Behaviour:
- Reset, synchronous, highest priority: out_valid=0, alu_in1=0, alu_in2=0, ins_dec_out=0.
- Field extraction: rs1=ins[19:15], rs2=ins[24:20], opcode=ins[6:0].
- Use mask from opcode:
  - LUI, AUIPC, JAL: no source registers.
  - OP-IMM, LOAD, JALR, SYSTEM: rs1 only.
  - OP, STORE, BRANCH: rs1 and rs2.
  - Any other opcode: both used.
  - An unused operand never forwards and never stalls; its output is rso value (don't-care, but deterministic).
- Operand select, per operand, combinational:
  - rs==0 -> 0. x0 never forwards and never stalls, even if fwd_rd==0.
  - Otherwise the lowest index i with fwd_valid[i] && fwd_rd[i]==rs wins -> fwd_data[i].
  - No match -> rso1 for operand 1, rso2 for operand 2 (independently).
- hazard = in_valid && (for either used operand, the winning match i has fwd_pend[i]=1). A pending older match shadowed by a non-pending younger match is not a hazard.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Transfer when in_valid && in_ready: register operands and ins, out_valid<=1 next cycle (latency 1).
  - Output consumed (out_valid && out_ready) with no transfer: out_valid<=0 (bubble). During hazard this inserts one bubble per stalled cycle.
  - out_valid && !out_ready: all outputs held stable; upstream holds ins_dec_in; forwarding is re-evaluated every cycle until transfer.
- flush: out_valid<=0 next cycle; incoming instruction not captured; flush beats transfer. Data registers may keep stale values.
- Simultaneous hazard and !out_ready: hold output, no capture.
- Width rules: operand registers are XLEN; instruction is always 32 bits.

Decomposition:
- Package rv32_pkg holds: opcode constants (OPC_LUI 0110111, OPC_AUIPC 0010111, OPC_JAL 1101111, OPC_JALR 1100111, OPC_BRANCH 1100011, OPC_LOAD 0000011, OPC_STORE 0100011, OPC_OPIMM 0010011, OPC_OP 0110011, OPC_SYSTEM 1110011), plus field bit positions.
- One sub-module, fwd_mux: a parametrised priority match/select for a single operand, with outputs data and pend_hit. Instantiated twice.

Test Plan:
- Reset mid-stream: out_valid=1 and alu_in1=0x55, assert rst one cycle -> next cycle out_valid=0, all outputs 0.
- ADD x3,x1,x2; fwd0 valid rd=1 data=0xAAAA0000; fwd1 valid rd=2 data=0x1234; rso1=rso2=0 -> alu_in1=0xAAAA0000, alu_in2=0x1234 one cycle later.
- Both fwd0 and fwd1 target rd=5 (data 0x11 and 0x22); ADD x6,x5,x5 -> both operands 0x11 (youngest wins).
- ADDI x1,x0,7 with fwd0 rd=0 data=0xFFFF -> alu_in1=0. ADDI with fwd0 pend=1 and rd equal to the rs2 field bits -> no hazard, transfers.
- Load-use: fwd0 valid pend rd=4, ADD x7,x4,x1 held 2 cycles -> hazard=1, in_ready=0, two bubbles. Drop pend with data 0x99 -> alu_in1=0x99, out_valid=1.
- out_ready=0 for 3 cycles while out_valid=1 -> outputs stable, in_ready=0. Then flush with in_valid=1 -> out_valid=0 next cycle, instruction dropped.
